dvp_tx: RTL
===========

# dvp_tx

Camera-side DVP transmitter: emits OV5640-style 8-bit parallel video (vsync, href, data) on the pixel clock from a stream of RGB565 pixels. Each pixel goes out as two bytes, high byte first, inside an href-qualified line, with vertical sync and blanking around the frame. The block feeds the capture path in bench and loopback builds, and drives any downstream DVP sink that expects camera-native timing.

## Interface
- CMOS_H_PIXEL, 12'd640: pixels per line (2× bytes per line).
- CMOS_V_PIXEL, 12'd480: active lines per frame.
- VSYNC_LEN, 16'd1920: vsync high time, cycles.
- V_BP_LINES, 8'd4: blank lines after vsync, before the first active line.
- V_FP_LINES, 8'd4: blank lines after the last active line.
- H_BLANK, 12'd256: href-low cycles after each line, active or blank.
- cmos_pclk  in  1  Sole clock; all logic on the rising edge.
- rst  in  1  Asynchronous, active-high reset.
- tx_en  in  1  Frame enable, sampled only in IDLE.
- pix_valid  in  1  Upstream pixel available.
- pix_data  in  16  RGB565 pixel.
- pix_ready  out  1  Pixel consumed this cycle when pix_ready && pix_valid.
- cmos_vsync  out  1  Vertical sync, active high.
- cmos_href  out  1  Line valid, active high.
- cmos_data  out  8  Byte data.
- frame_cnt  out  16  Completed frames, wraps at 16'hFFFF→0.
- underflow  out  1  Sticky. Set on pixel starvation, cleared only by rst.

## Operation
- FSM states: IDLE → VSYNC → VBP → ACTIVE → VFP → IDLE, or → VSYNC directly if tx_en is high.
- IDLE: all video outputs low. When tx_en=1, go to VSYNC next cycle.
- VSYNC: cmos_vsync=1 for exactly VSYNC_LEN cycles. Then H_BLANK idle cycles, then VBP.
- VBP / VFP: V_BP_LINES / V_FP_LINES lines. Each line is 2·CMOS_H_PIXEL cycles of href=0 followed by H_BLANK cycles of href=0.
- ACTIVE: CMOS_V_PIXEL lines. Each line is 2·CMOS_H_PIXEL cycles of href=1 followed by H_BLANK cycles of href=0.
- Byte order within a line: even byte = pix_data[15:8], odd byte = pix_data[7:0] of the same consumed pixel.
- Byte counter: 13 bits, counts 0 … 2·CMOS_H_PIXEL+H_BLANK−1. Line counter: 12 bits. Both clear at the start of each phase.
- pix_ready is high for exactly one cycle per pixel: the cycle before that pixel's even byte is driven. It is never high outside ACTIVE.
- Starvation: if pix_valid=0 when pix_ready=1, the pixel is emitted as 16'h0000, underflow is set, and timing is unaffected. The line never stalls.
- tx_en is ignored mid-frame. A frame always completes.
- frame_cnt increments in the last VFP cycle.
- rst asserted mid-frame: immediate return to IDLE with all outputs at reset values. The next frame starts from VSYNC.

## Timing
- Reset values: cmos_vsync=0, cmos_href=0, cmos_data=8'h00, pix_ready=0, frame_cnt=0, underflow=0.
- cmos_vsync, cmos_href and cmos_data are registered. cmos_data is 8'h00 whenever href=0.
- Latency from pix_ready&&pix_valid at cycle N: high byte at N+1, low byte at N+2, with href=1 in both.
- Frame period = VSYNC_LEN + H_BLANK + (V_BP_LINES + CMOS_V_PIXEL + V_FP_LINES)·(2·CMOS_H_PIXEL + H_BLANK) cycles, plus 1 IDLE cycle when tx_en is low at frame end.
- tx_en=1 in IDLE at cycle N → cmos_vsync=1 at N+2.

## Configuration
- DVP_TX_PATTERN_EN defined: pix_data and pix_valid are ignored, and pixels come from an internal 8-bar colour pattern. Bar index = pixel_x·8/CMOS_H_PIXEL. Bars in order: white, yellow, cyan, green, magenta, red, blue, black. pix_ready stays 0 and underflow never sets.
- Macro undefined: external stream as described above.

## Structure
- Package dvp_pkg: FSM state enum (IDLE, VSYNC, VBP, ACTIVE, VFP) and the eight RGB565 bar constants (16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000).
- One sub-module: dvp_pattern_gen (pixel_x in → RGB565 out, registered), instantiated only under DVP_TX_PATTERN_EN.

## Test plan
Bench parameters for all scenarios: H=4, V=2, VSYNC_LEN=3, V_BP_LINES=1, V_FP_LINES=1, H_BLANK=4.
- Frame shape: tx_en held 1, pix_valid held 1 → vsync high 3 cycles; frame period 3+4+4·12 = 55 cycles; two href bursts of 8 cycles each, separated by 4 low cycles; frame_cnt=1 after the first frame.
- Byte order: pixels 16'hA1B2, 16'hC3D4, … → cmos_data = A1, B2, C3, D4, … with href=1; pix_ready pulses 4 times per active line, every second cycle.
- Starvation: pix_valid=0 for the 3rd pixel of line 0 → bytes 5–6 of line 0 are 00 00; underflow=1 and stays 1; line length is unchanged.
- Mid-frame control: tx_en dropped during ACTIVE → the frame completes, then IDLE with outputs low; tx_en raised again → vsync 2 cycles later.
- Reset mid-line: rst pulsed during href → next cycle all outputs 0, frame_cnt=0; a new frame starts from VSYNC.
- With DVP_TX_PATTERN_EN (H=8): line bytes = FF FF, FF E0, 07 FF, 07 E0, F8 1F, F8 00, 00 1F, 00 00; pix_ready never asserted.

Source files
------------

// File: rtl/dvp_pkg.sv
// Shared types for the DVP transmitter: frame FSM states and the colour-bar palette.
package dvp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } dvp_state_t;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_rgb(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Eight vertical colour bars: registered RGB565 colour for the given pixel column.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter logic [11:0] CMOS_H_PIXEL = 12'd640
) (
  input  logic        cmos_pclk,
  input  logic        rst,
  input  logic [11:0] pixel_x,
  output logic [15:0] rgb
);

  logic [14:0] scaled;
  logic [14:0] bar_idx;

  always_comb begin
    scaled  = {pixel_x, 3'b000};
    bar_idx = scaled / 15'(CMOS_H_PIXEL);
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      rgb <= '0;
    end else if (bar_idx > 15'd7) begin
      rgb <= RGB_BLACK;
    end else begin
      rgb <= bar_rgb(bar_idx[2:0]);
    end
  end

endmodule

// File: rtl/dvp_tx.sv
// OV5640-style DVP transmitter: RGB565 pixel stream to vsync/href/8-bit data on cmos_pclk.
// Define DVP_TX_PATTERN_EN to replace the external stream with an internal 8-bar pattern.
module dvp_tx
  import dvp_pkg::*;
#(
  parameter logic [11:0] CMOS_H_PIXEL = 12'd640,
  parameter logic [11:0] CMOS_V_PIXEL = 12'd480,
  parameter logic [15:0] VSYNC_LEN    = 16'd1920,
  parameter logic [7:0]  V_BP_LINES   = 8'd4,
  parameter logic [7:0]  V_FP_LINES   = 8'd4,
  parameter logic [11:0] H_BLANK      = 12'd256
) (
  input  logic        cmos_pclk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic        pix_valid,
  input  logic [15:0] pix_data,
  output logic        pix_ready,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_data,
  output logic [15:0] frame_cnt,
  output logic        underflow
);

  localparam logic [12:0] ACT_BYTES = {CMOS_H_PIXEL, 1'b0};
  localparam logic [12:0] LINE_LEN  = ACT_BYTES + 13'(H_BLANK);
  localparam logic [16:0] VS_TOTAL  = 17'(VSYNC_LEN) + 17'(H_BLANK);

  dvp_state_t  state;
  dvp_state_t  state_nxt;
  logic [12:0] byte_cnt;
  logic [11:0] line_cnt;
  logic [16:0] vs_cnt;

  logic        line_end;
  logic        vs_end;
  logic        bp_last;
  logic        act_last;
  logic        fp_last;
  logic        frame_end;

  logic        vsync_d;
  logic        href_d;
  logic [7:0]  data_d;
  logic [7:0]  hi_byte;
  logic [7:0]  lo_byte;
  logic        starve;

  always_comb begin
    line_end  = (byte_cnt == LINE_LEN - 13'd1);
    vs_end    = (vs_cnt == VS_TOTAL - 17'd1);
    bp_last   = (line_cnt == {4'b0, V_BP_LINES} - 12'd1);
    act_last  = (line_cnt == CMOS_V_PIXEL - 12'd1);
    fp_last   = (line_cnt == {4'b0, V_FP_LINES} - 12'd1);
    frame_end = (state == VFP) && line_end && fp_last;
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tx_en)                 state_nxt = VSYNC;
      VSYNC:   if (vs_end)                state_nxt = VBP;
      VBP:     if (line_end && bp_last)   state_nxt = ACTIVE;
      ACTIVE:  if (line_end && act_last)  state_nxt = VFP;
      VFP:     if (frame_end)             state_nxt = tx_en ? VSYNC : IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  // Counters restart on every phase change so each phase times itself from zero.
  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      vs_cnt   <= '0;
    end else if (state_nxt != state) begin
      byte_cnt <= '0;
      line_cnt <= '0;
      vs_cnt   <= '0;
    end else begin
      case (state)
        VSYNC: vs_cnt <= vs_cnt + 17'd1;
        VBP, ACTIVE, VFP: begin
          if (line_end) begin
            byte_cnt <= '0;
            line_cnt <= line_cnt + 12'd1;
          end else begin
            byte_cnt <= byte_cnt + 13'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    vsync_d = (state == VSYNC) && (vs_cnt < 17'(VSYNC_LEN));
    href_d  = (state == ACTIVE) && (byte_cnt < ACT_BYTES);
  end

`ifdef DVP_TX_PATTERN_EN
  logic [11:0] pat_x;
  logic [15:0] pat_rgb;

  // The generator is registered, so it is fed the column one cycle ahead; the last
  // blanking cycle of any line primes column 0 for the next line.
  always_comb begin
    pat_x = line_end ? '0 : 12'((byte_cnt + 13'd1) >> 1);
  end

  dvp_pattern_gen #(
    .CMOS_H_PIXEL(CMOS_H_PIXEL)
  ) u_pattern (
    .cmos_pclk(cmos_pclk),
    .rst      (rst),
    .pixel_x  (pat_x),
    .rgb      (pat_rgb)
  );

  always_comb begin
    pix_ready = 1'b0;
    starve    = 1'b0;
    hi_byte   = pat_rgb[15:8];
    lo_byte   = pat_rgb[7:0];
  end
`else
  logic [7:0] lo_q;

  always_comb begin
    pix_ready = href_d && !byte_cnt[0];
    starve    = pix_ready && !pix_valid;
    hi_byte   = pix_valid ? pix_data[15:8] : '0;
    lo_byte   = lo_q;
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
    end else if (pix_ready) begin
      lo_q <= pix_valid ? pix_data[7:0] : '0;
    end
  end
`endif

  always_comb begin
    data_d = '0;
    if (href_d) begin
      data_d = byte_cnt[0] ? lo_byte : hi_byte;
    end
  end

  always_ff @(posedge cmos_pclk or posedge rst) begin
    if (rst) begin
      cmos_vsync <= 1'b0;
      cmos_href  <= 1'b0;
      cmos_data  <= '0;
      frame_cnt  <= '0;
      underflow  <= 1'b0;
    end else begin
      cmos_vsync <= vsync_d;
      cmos_href  <= href_d;
      cmos_data  <= data_d;
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (starve) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
